// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
// Shared definitions for the ACCUM sequencer/arbiter (accum_sched):
//   - accum_state_t : sequencer FSM states
//   - NZ_DEF/NP_DEF : default zero/pole term counts per operation
//   - TERM_W        : width of the term_idx output
// -----------------------------------------------------------------------------
package accum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ZERO  = 3'd2,
    ST_POLE  = 3'd3,
    ST_DONE  = 3'd4
  } accum_state_t;

  localparam int NZ_DEF = 6;
  localparam int NP_DEF = 2;
  localparam int TERM_W = 4;

endpackage : accum_pkg

// File: rtl/accum_rr_arb.sv
// -----------------------------------------------------------------------------
// accum_rr_arb
// Combinational round-robin select: picks the first set request bit at or
// after ptr, wrapping modulo NCH. The pointer register lives in the caller.
// Ports:
//   req   in  [NCH-1:0]  request vector
//   ptr   in  [CHW-1:0]  highest-priority channel index
//   gnt   out [NCH-1:0]  one-hot grant (zero when no request)
//   idx   out [CHW-1:0]  index of the granted channel
//   valid out            at least one request is set
// -----------------------------------------------------------------------------
module accum_rr_arb #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] idx,
  output logic           valid
);

  localparam int SW = CHW + 1;

  // cand[i] is the channel sitting i places after ptr in priority order
  logic [CHW-1:0] cand [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum       = {1'b0, ptr} + SW'(gi);
    assign cand[gi]  = (sum >= SW'(NCH)) ? CHW'(sum - SW'(NCH)) : sum[CHW-1:0];
  end

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Walk from lowest to highest priority so the nearest match wins last.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        valid = 1'b1;
        idx   = cand[i];
      end
    end
    gnt = valid ? (NCH'(1) << idx) : '0;
  end

endmodule : accum_rr_arb

// File: rtl/accum_sched.sv
// -----------------------------------------------------------------------------
// accum_sched
// Round-robin sequencer for the shared MCAC predictor accumulator. Grants one
// of NCH requesters, clears the accumulator, steps NZ zero terms then NP pole
// terms (stalling on acc_rdy=0), strobes SEZ/SE capture and pulses done.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   req      [NCH-1:0]    level requests, held until the matching done bit
//   acc_rdy               datapath accepts a term this cycle
//   gnt      [NCH-1:0]    one-hot grant, held from grant through DONE
//   acc_ch   [CHW-1:0]    channel of the current operation
//   acc_clr               accumulator clear pulse
//   acc_en                term term_idx is added this cycle
//   term_idx [3:0]        0..NZ-1 zero terms, NZ..NZ+NP-1 pole terms
//   sez_ld, se_ld         partial / full sum capture strobes
//   done     [NCH-1:0]    one-cycle one-hot completion pulse
//   busy                  FSM not idle
//   scan_in0, scan_en     scan chain inputs, unused before scan insertion
//   scan_out0             scan output, tied 0 before scan insertion
// Optional (macro ACCUM_SCHED_STALL_CNT_EN):
//   stall_cnt [15:0]      saturating count of stalled ZERO/POLE cycles
// -----------------------------------------------------------------------------
module accum_sched
  import accum_pkg::*;
#(
  parameter int NCH = 4,
  parameter int NZ  = NZ_DEF,
  parameter int NP  = NP_DEF,
  parameter int CHW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic              acc_rdy,
  output logic [NCH-1:0]    gnt,
  output logic [CHW-1:0]    acc_ch,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [TERM_W-1:0] term_idx,
  output logic              sez_ld,
  output logic              se_ld,
  output logic [NCH-1:0]    done,
  output logic              busy,
  input  logic              scan_in0,
  input  logic              scan_en,
  output logic              scan_out0
`ifdef ACCUM_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [TERM_W-1:0] LAST_Z = TERM_W'(NZ - 1);
  localparam logic [TERM_W-1:0] LAST_P = TERM_W'(NZ + NP - 1);

  accum_state_t      state_q, state_d;
  logic [CHW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0]    gnt_q, gnt_d;
  logic [CHW-1:0]    acc_ch_q, acc_ch_d;
  logic [TERM_W-1:0] term_q, term_d;
  logic              acc_clr_q, acc_clr_d;
  logic              sez_ld_q, sez_ld_d;
  logic              se_ld_q, se_ld_d;
  logic [NCH-1:0]    done_q, done_d;

  logic [CHW-1:0]    ptr_inc;
  logic [CHW-1:0]    arb_ptr;
  logic [NCH-1:0]    arb_gnt;
  logic [CHW-1:0]    arb_idx;
  logic              arb_valid;
  logic              in_terms;
  logic              unused_scan;

  assign unused_scan = &{1'b0, scan_in0, scan_en};
  assign scan_out0   = 1'b0;

  assign ptr_inc = (acc_ch_q == CHW'(NCH - 1)) ? '0 : acc_ch_q + CHW'(1);
  // In DONE the pointer already moves past the finishing channel, so a
  // back-to-back grant sees the updated priority without an idle bubble.
  assign arb_ptr = (state_q == ST_DONE) ? ptr_inc : rr_ptr_q;

  accum_rr_arb #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req   (req),
    .ptr   (arb_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign in_terms = (state_q == ST_ZERO) || (state_q == ST_POLE);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    acc_ch_d  = acc_ch_q;
    term_d    = term_q;
    acc_clr_d = 1'b0;
    sez_ld_d  = 1'b0;
    se_ld_d   = 1'b0;
    done_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d     = arb_gnt;
          acc_ch_d  = arb_idx;
          acc_clr_d = 1'b1;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        term_d  = '0;
        state_d = ST_ZERO;
      end
      ST_ZERO: begin
        if (acc_rdy) begin
          if (term_q == LAST_Z) begin
            sez_ld_d = 1'b1;
            if (NP == 0) begin
              se_ld_d = 1'b1;
              done_d  = gnt_q;
              term_d  = '0;
              state_d = ST_DONE;
            end else begin
              term_d  = term_q + TERM_W'(1);
              state_d = ST_POLE;
            end
          end else begin
            term_d = term_q + TERM_W'(1);
          end
        end
      end
      ST_POLE: begin
        if (acc_rdy) begin
          if (term_q == LAST_P) begin
            se_ld_d = 1'b1;
            done_d  = gnt_q;
            term_d  = '0;
            state_d = ST_DONE;
          end else begin
            term_d = term_q + TERM_W'(1);
          end
        end
      end
      ST_DONE: begin
        rr_ptr_d = ptr_inc;
        if (arb_valid) begin
          gnt_d     = arb_gnt;
          acc_ch_d  = arb_idx;
          acc_clr_d = 1'b1;
          state_d   = ST_CLEAR;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      acc_ch_q  <= '0;
      term_q    <= '0;
      acc_clr_q <= 1'b0;
      sez_ld_q  <= 1'b0;
      se_ld_q   <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      acc_ch_q  <= acc_ch_d;
      term_q    <= term_d;
      acc_clr_q <= acc_clr_d;
      sez_ld_q  <= sez_ld_d;
      se_ld_q   <= se_ld_d;
      done_q    <= done_d;
    end
  end

  assign gnt      = gnt_q;
  assign acc_ch   = acc_ch_q;
  assign acc_clr  = acc_clr_q;
  assign acc_en   = in_terms && acc_rdy;
  assign term_idx = term_q;
  assign sez_ld   = sez_ld_q;
  assign se_ld    = se_ld_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef ACCUM_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_terms && !acc_rdy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : accum_sched
